acr_packet_generator: RTL and testbench

- Parametrised HDMI Audio Clock Regeneration (ACR) packet source with runtime N.
- Measures CTS over multiple windows, averages it, and offers each packet on a valid/ready handshake to the packet scheduler.
- Also supports a fixed-CTS mode.
- Single clk_pixel domain. Audio timing arrives as a pre-synchronised one-cycle pulse per audio sample.

---
 rtl/acr_packet_generator.sv | 184 ++++++++++++++++++
 tb/tb_acr_packet_generator.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/acr_packet_generator.sv
// ============================================================================
// Module   : acr_packet_generator
// Purpose  : HDMI ACR packet source; measured/averaged or fixed CTS, runtime N.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module acr_packet_generator #(
    parameter int CTS_WIDTH = 20,
    parameter int AVG_LOG2  = 2,
    parameter int DEFAULT_N = 6144
) (
    input  logic             clk_pixel,
    input  logic             reset,
    input  logic             audio_tick,
    input  logic [19:0]      n_value,
    input  logic             cts_mode,
    input  logic [19:0]      cts_fixed,
    input  logic             packet_ready,
    output logic             packet_valid,
    output logic [23:0]      header,
    output logic [3:0][55:0] sub,
    output logic [19:0]      cts_value,
    output logic             cts_locked,
    output logic             cts_overflow
);

    localparam int c_ACC_W = CTS_WIDTH + AVG_LOG2;
    localparam int c_GW    = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
    localparam int c_ROUND = (2 ** AVG_LOG2) / 2;
    localparam logic [c_GW-1:0] c_GRP_LAST = c_GW'((2 ** AVG_LOG2) - 1);

    logic [19:0]          r_n;
    logic                 r_mode;
    logic [12:0]          r_tick_cnt;
    logic [CTS_WIDTH-1:0] r_pix_cnt;
    logic [c_ACC_W-1:0]   r_acc;
    logic [c_GW-1:0]      r_grp;
    logic                 r_discard;

    logic                 r_pend_valid;
    logic [19:0]          r_pend_cts;
    logic [19:0]          r_pend_n;
    logic [19:0]          r_out_n;

    logic [12:0]          w_d;
    logic                 w_restart;
    logic                 w_sat;
    logic                 w_win_end;
    logic [c_ACC_W:0]     w_win_cts;
    logic [c_ACC_W:0]     w_sum;
    logic [c_ACC_W:0]     w_rnd;
    logic                 w_res_valid;
    logic [19:0]          w_res_cts;
    logic                 w_accept;

    assign w_d       = n_value[19:7];
    assign w_restart = (n_value != r_n) || (cts_mode != r_mode) || (w_d == 13'd0);
    assign w_sat     = &r_pix_cnt;
    assign w_win_end = !w_restart && audio_tick && (r_tick_cnt == (w_d - 13'd1));
    // The ending cycle belongs to the window, hence the +1.
    assign w_win_cts = {{(AVG_LOG2 + 1){1'b0}}, r_pix_cnt} + 1'b1;
    assign w_sum     = {1'b0, r_acc} + w_win_cts;
    assign w_rnd     = w_sum + (c_ACC_W + 1)'(c_ROUND);
    assign w_accept  = packet_valid && packet_ready;

    always_comb begin
        w_res_valid = 1'b0;
        w_res_cts   = 20'd0;
        if (w_win_end) begin
            if (cts_mode) begin
                w_res_valid = 1'b1;
                w_res_cts   = cts_fixed;
            end else if (!r_discard && !w_sat && (r_grp == c_GRP_LAST)) begin
                w_res_valid = 1'b1;
                w_res_cts   = 20'(w_rnd >> AVG_LOG2);
            end
        end
    end

    always_ff @(posedge clk_pixel or posedge reset) begin
        if (reset) begin
            r_n          <= 20'(DEFAULT_N);
            r_mode       <= 1'b0;
            r_tick_cnt   <= '0;
            r_pix_cnt    <= '0;
            r_acc        <= '0;
            r_grp        <= '0;
            r_discard    <= 1'b1;
            cts_locked   <= 1'b0;
            cts_overflow <= 1'b0;
        end else begin
            r_n    <= n_value;
            r_mode <= cts_mode;
            if (w_restart) begin
                r_tick_cnt   <= '0;
                r_pix_cnt    <= '0;
                r_acc        <= '0;
                r_grp        <= '0;
                r_discard    <= 1'b1;
                cts_locked   <= 1'b0;
                cts_overflow <= 1'b0;
            end else begin
                if (w_win_end) begin
                    r_pix_cnt <= '0;
                end else if (!w_sat) begin
                    r_pix_cnt <= r_pix_cnt + 1'b1;
                end
                if (w_win_end) begin
                    r_tick_cnt <= '0;
                end else if (audio_tick) begin
                    r_tick_cnt <= r_tick_cnt + 13'd1;
                end
                if (w_win_end) begin
                    if (cts_mode) begin
                        r_discard  <= 1'b0;
                        cts_locked <= 1'b1;
                    end else if (r_discard) begin
                        r_discard <= 1'b0;
                    end else if (w_sat) begin
                        // A saturated window poisons the whole group: drop it and start over.
                        cts_overflow <= 1'b1;
                        cts_locked   <= 1'b0;
                        r_acc        <= '0;
                        r_grp        <= '0;
                    end else if (r_grp == c_GRP_LAST) begin
                        cts_locked <= 1'b1;
                        r_acc      <= '0;
                        r_grp      <= '0;
                    end else begin
                        r_acc <= w_sum[c_ACC_W-1:0];
                        r_grp <= r_grp + 1'b1;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk_pixel or posedge reset) begin
        if (reset) begin
            packet_valid <= 1'b0;
            cts_value    <= 20'd0;
            r_out_n      <= 20'd0;
            r_pend_valid <= 1'b0;
            r_pend_cts   <= 20'd0;
            r_pend_n     <= 20'd0;
        end else begin
            if (w_res_valid) begin
                if (!packet_valid || w_accept) begin
                    packet_valid <= 1'b1;
                    cts_value    <= w_res_cts;
                    r_out_n      <= r_n;
                    r_pend_valid <= 1'b0;
                end else begin
                    r_pend_valid <= 1'b1;
                    r_pend_cts   <= w_res_cts;
                    r_pend_n     <= r_n;
                end
            end else if (w_accept) begin
                if (r_pend_valid) begin
                    packet_valid <= 1'b1;
                    cts_value    <= r_pend_cts;
                    r_out_n      <= r_pend_n;
                    r_pend_valid <= 1'b0;
                end else begin
                    packet_valid <= 1'b0;
                end
            end
        end
    end

    assign header = {8'h00, 8'h00, 8'h01};

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_sub
            assign sub[gi] = {r_out_n[7:0], r_out_n[15:8], 4'd0, r_out_n[19:16],
                              cts_value[7:0], cts_value[15:8], 4'd0, cts_value[19:16],
                              8'd0};
        end
    endgenerate

endmodule

`default_nettype wire

// File: tb/tb_acr_packet_generator.sv
// ============================================================================
// Module   : tb_acr_packet_generator
// Purpose  : Scoreboard bench for acr_packet_generator (CTS_WIDTH=12 instance).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_acr_packet_generator;

    logic             clk_pixel;
    logic             reset;
    logic             audio_tick;
    logic [19:0]      n_value;
    logic             cts_mode;
    logic [19:0]      cts_fixed;
    logic             packet_ready;
    logic             packet_valid;
    logic [23:0]      header;
    logic [3:0][55:0] sub;
    logic [19:0]      cts_value;
    logic             cts_locked;
    logic             cts_overflow;

    int total = 0;
    int bad   = 0;
    logic [39:0] exp_q[$];
    logic        prev_held;
    logic [19:0] prev_cts;

    acr_packet_generator #(
        .CTS_WIDTH (12),
        .AVG_LOG2  (2),
        .DEFAULT_N (6144)
    ) u_dut (
        .clk_pixel    (clk_pixel),
        .reset        (reset),
        .audio_tick   (audio_tick),
        .n_value      (n_value),
        .cts_mode     (cts_mode),
        .cts_fixed    (cts_fixed),
        .packet_ready (packet_ready),
        .packet_valid (packet_valid),
        .header       (header),
        .sub          (sub),
        .cts_value    (cts_value),
        .cts_locked   (cts_locked),
        .cts_overflow (cts_overflow)
    );

    initial begin
        clk_pixel = 1'b0;
        forever #5 clk_pixel = ~clk_pixel;
    end

    function automatic void check(input string nm, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, req);
        end
    endfunction

    function automatic logic [55:0] exp_sub(input logic [19:0] c, input logic [19:0] n);
        return {n[7:0], n[15:8], 4'd0, n[19:16], c[7:0], c[15:8], 4'd0, c[19:16], 8'd0};
    endfunction

    // Monitor: every accepted packet is matched against the next expected entry.
    always @(negedge clk_pixel) begin
        if (reset) begin
            prev_held = 1'b0;
        end else begin
            if (prev_held) begin
                check("held_valid", {63'd0, packet_valid}, 64'd1);
                check("held_cts", {44'd0, cts_value}, {44'd0, prev_cts});
            end
            if (packet_valid && packet_ready) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_packet actual_cts=%0d required=none", cts_value);
                end else begin
                    logic [39:0] e;
                    e = exp_q.pop_front();
                    check("pkt_cts", {44'd0, cts_value}, {44'd0, e[39:20]});
                    for (int i = 0; i < 4; i++)
                        check("pkt_sub", {8'd0, sub[i]}, {8'd0, exp_sub(e[39:20], e[19:0])});
                    check("pkt_header", {40'd0, header}, 64'h000001);
                    check("pkt_locked", {63'd0, cts_locked}, 64'd1);
                end
            end
            prev_held = packet_valid && !packet_ready;
            prev_cts  = cts_value;
        end
    end

    task automatic idle(input int n);
        repeat (n) @(posedge clk_pixel);
        #1;
    endtask

    // Places a tick so it is sampled exactly 'gap' edges after the previous call's tick.
    task automatic tick(input int gap);
        repeat (gap - 1) @(posedge clk_pixel);
        #1 audio_tick = 1'b1;
        @(posedge clk_pixel);
        #1 audio_tick = 1'b0;
    endtask

    initial begin
        reset        = 1'b1;
        audio_tick   = 1'b0;
        n_value      = 20'd6144;
        cts_mode     = 1'b0;
        cts_fixed    = 20'd0;
        packet_ready = 1'b1;
        prev_held    = 1'b0;
        prev_cts     = 20'd0;

        repeat (3) @(negedge clk_pixel);
        check("rst_valid", {63'd0, packet_valid}, 64'd0);
        check("rst_cts", {44'd0, cts_value}, 64'd0);
        check("rst_locked", {63'd0, cts_locked}, 64'd0);
        check("rst_ovf", {63'd0, cts_overflow}, 64'd0);
        check("rst_sub", {8'd0, sub[0]}, 64'd0);
        check("rst_header", {40'd0, header}, 64'h000001);
        @(posedge clk_pixel);
        #1 reset = 1'b0;

        // Discard window then four 48-tick windows of 480 cycles each.
        exp_q.push_back({20'd480, 20'd6144});
        repeat (5 * 48) tick(10);
        idle(4);
        check("n6144_cts", {44'd0, cts_value}, 64'd480);
        check("n6144_sub_literal", {8'd0, sub[0]}, {8'd0, 56'h00_18_00_E0_01_00_00});
        check("n6144_locked", {63'd0, cts_locked}, 64'd1);
        check("n6144_valid_drop", {63'd0, packet_valid}, 64'd0);

        // D=1: every tick ends a window; averaging and round-half-up.
        n_value = 20'd128;
        exp_q.push_back({20'd101, 20'd128});
        exp_q.push_back({20'd101, 20'd128});
        exp_q.push_back({20'd100, 20'd128});
        tick(50);
        tick(100); tick(101); tick(101); tick(101);
        tick(100); tick(100); tick(101); tick(101);
        tick(100); tick(100); tick(100); tick(101);
        idle(3);

        // Back-pressure across two results: first held, second pending.
        packet_ready = 1'b0;
        exp_q.push_back({20'd200, 20'd128});
        exp_q.push_back({20'd210, 20'd128});
        tick(197); tick(200); tick(200); tick(200);
        tick(210); tick(210); tick(210); tick(210);
        idle(3);
        check("held_first_valid", {63'd0, packet_valid}, 64'd1);
        check("held_first_cts", {44'd0, cts_value}, 64'd200);
        packet_ready = 1'b1;
        @(negedge clk_pixel);
        check("accept_old_cts", {44'd0, cts_value}, 64'd200);
        idle(1);
        @(negedge clk_pixel);
        check("b2b_valid", {63'd0, packet_valid}, 64'd1);
        check("b2b_cts", {44'd0, cts_value}, 64'd210);
        idle(1);
        @(negedge clk_pixel);
        check("after_b2b_valid", {63'd0, packet_valid}, 64'd0);
        idle(1);

        // Lock at N=6144, then change N mid-window.
        n_value = 20'd6144;
        exp_q.push_back({20'd480, 20'd6144});
        repeat (5 * 48 + 20) tick(10);
        @(negedge clk_pixel);
        check("pre_change_locked", {63'd0, cts_locked}, 64'd1);
        idle(1);
        n_value = 20'd12288;
        idle(1);
        @(negedge clk_pixel);
        check("change_unlocked", {63'd0, cts_locked}, 64'd0);
        idle(1);
        exp_q.push_back({20'd960, 20'd12288});
        repeat (5 * 96) tick(10);
        idle(4);
        check("n12288_cts", {44'd0, cts_value}, 64'd960);

        // Fixed CTS: no discard, a packet per window.
        cts_mode  = 1'b1;
        cts_fixed = 20'd27000;
        n_value   = 20'd128;
        idle(1);
        @(negedge clk_pixel);
        check("fixed_unlocked", {63'd0, cts_locked}, 64'd0);
        idle(1);
        repeat (3) exp_q.push_back({20'd27000, 20'd128});
        tick(20);
        @(negedge clk_pixel);
        check("fixed_locked_first", {63'd0, cts_locked}, 64'd1);
        idle(1);
        tick(20); tick(20);
        idle(4);

        // Measured lock, then a window that saturates the 12-bit counter.
        cts_mode = 1'b0;
        exp_q.push_back({20'd50, 20'd128});
        tick(20);
        tick(50); tick(50); tick(50); tick(50);
        idle(3);
        check("pre_ovf_locked", {63'd0, cts_locked}, 64'd1);
        check("pre_ovf_flag", {63'd0, cts_overflow}, 64'd0);
        tick(4300);
        @(negedge clk_pixel);
        check("ovf_flag", {63'd0, cts_overflow}, 64'd1);
        check("ovf_unlocked", {63'd0, cts_locked}, 64'd0);
        check("ovf_no_packet", {63'd0, packet_valid}, 64'd0);
        idle(5);

        // Asynchronous reset between clock edges.
        @(negedge clk_pixel);
        #2 reset = 1'b1;
        #1;
        check("arst_valid", {63'd0, packet_valid}, 64'd0);
        check("arst_cts", {44'd0, cts_value}, 64'd0);
        check("arst_locked", {63'd0, cts_locked}, 64'd0);
        check("arst_ovf", {63'd0, cts_overflow}, 64'd0);
        check("arst_sub", {8'd0, sub[3]}, 64'd0);
        #20 reset = 1'b0;

        check("queue_empty", 64'(exp_q.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
